// File: rtl/ttt_cursor_display_pkg.sv
// Shared tic-tac-toe definitions: cell encodings, board size, cursor FSM states
// and small helpers for board occupancy and wrapping cursor moves.
package ttt_cursor_display_pkg;

    localparam int NUM_CELLS = 9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    // Code 2'b11 is not a legal mark and counts as empty.
    function automatic logic [NUM_CELLS-1:0] occupancy(input logic [2*NUM_CELLS-1:0] board);
        logic [NUM_CELLS-1:0] occ;
        for (int i = 0; i < NUM_CELLS; i++) begin
            occ[i] = (board[2*i +: 2] == CELL_X) || (board[2*i +: 2] == CELL_O);
        end
        return occ;
    endfunction

    function automatic logic [3:0] next_cell(input logic [3:0] c);
        return (c == 4'(NUM_CELLS - 1)) ? 4'd0 : c + 4'd1;
    endfunction

    function automatic logic [3:0] prev_cell(input logic [3:0] c);
        return (c == 4'd0) ? 4'(NUM_CELLS - 1) : c - 4'd1;
    endfunction

endpackage

// File: rtl/ttt_cursor_display_btn_edge.sv
// Rising-edge detector for the debounced buttons. History resets to 1 so a
// button held through reset produces no event until it is released and pressed.
module ttt_cursor_display_btn_edge #(
    parameter int W = 3
) (
    input  logic         CLOCK_60Hz,
    input  logic         reset,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] hist_p0;

    always_ff @(posedge CLOCK_60Hz) begin
        if (reset) begin
            hist_p0 <= '1;
        end else begin
            hist_p0 <= level;
        end
    end

    assign rise = level & ~hist_p0;

endmodule

// File: rtl/ttt_cursor_display.sv
// Player cursor for the 3x3 board: moves on button events, issues placement
// requests, auto-advances to the next free cell and drives the blinking LEDs.
module ttt_cursor_display
    import ttt_cursor_display_pkg::*;
#(
    parameter int CURSOR_RESET = 4,
    parameter int NUM_CELLS    = 9
) (
    input  logic                   CLOCK_60Hz,
    input  logic                   reset,
    input  logic                   blink,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_select,
    input  logic [2*NUM_CELLS-1:0] board,
    input  logic                   player,
    input  logic                   game_over,
    output logic [3:0]             cursor,
    output logic                   place_valid,
    output logic                   place_reject,
    output logic [3:0]             place_cell,
    output logic [NUM_CELLS-1:0]   led_x,
    output logic [NUM_CELLS-1:0]   led_o
);

    logic [2:0]           rise;
    logic                 ev_left, ev_right, ev_select;
    logic [NUM_CELLS-1:0] occ;

    state_t               state_p1, state_nxt;
    logic [3:0]           cursor_p1, cursor_nxt;
    logic [3:0]           home_p1, home_nxt;
    logic [NUM_CELLS-1:0] mask_p1, mask_nxt;
    logic [2:0]           step_p1, step_nxt;
    logic                 vld_nxt, rej_nxt;

    logic [NUM_CELLS-1:0] base_x, base_o;
    logic [NUM_CELLS-1:0] led_x_nxt, led_o_nxt;

    ttt_cursor_display_btn_edge #(.W(3)) u_btn_edge (
        .CLOCK_60Hz (CLOCK_60Hz),
        .reset      (reset),
        .level      ({btn_select, btn_right, btn_left}),
        .rise       (rise)
    );

    assign ev_left   = rise[0];
    assign ev_right  = rise[1];
    assign ev_select = rise[2];
    assign occ       = occupancy(board);

    // Stage 0 -> 1: cursor FSM decisions from button events and board state
    always_comb begin
        state_nxt  = state_p1;
        cursor_nxt = cursor_p1;
        home_nxt   = home_p1;
        mask_nxt   = mask_p1;
        step_nxt   = step_p1;
        vld_nxt    = 1'b0;
        rej_nxt    = 1'b0;

        case (state_p1)
            IDLE: begin
                if (ev_select) begin
                    if (game_over || occ[cursor_p1]) begin
                        rej_nxt = 1'b1;
                    end else begin
                        vld_nxt   = 1'b1;
                        mask_nxt  = occ | (NUM_CELLS'(1) << cursor_p1);
                        home_nxt  = cursor_p1;
                        step_nxt  = 3'd0;
                        state_nxt = SEARCH;
                    end
                end else if (!game_over && (ev_left ^ ev_right)) begin
                    cursor_nxt = ev_right ? next_cell(cursor_p1) : prev_cell(cursor_p1);
                end
            end

            SEARCH: begin
                // Snapshot mask, not the live board: the board lags the placement.
                if (game_over) begin
                    state_nxt = IDLE;
                end else begin
                    step_nxt = step_p1 + 3'd1;
                    if (!mask_p1[next_cell(cursor_p1)]) begin
                        cursor_nxt = next_cell(cursor_p1);
                        state_nxt  = IDLE;
                    end else if (step_p1 == 3'd7) begin
                        cursor_nxt = home_p1;
                        state_nxt  = IDLE;
                    end else begin
                        cursor_nxt = next_cell(cursor_p1);
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        base_x = '0;
        base_o = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            base_x[i] = (board[2*i +: 2] == CELL_X);
            base_o[i] = (board[2*i +: 2] == CELL_O);
        end
    end

    // Stage 0 -> 1: LED pattern with the cursor cell blink override
    always_comb begin
        led_x_nxt = base_x;
        led_o_nxt = base_o;
        if (!game_over) begin
            if (!occ[cursor_p1]) begin
                if (player) begin
                    led_o_nxt[cursor_p1] = blink;
                end else begin
                    led_x_nxt[cursor_p1] = blink;
                end
            end else begin
                led_x_nxt[cursor_p1] = base_x[cursor_p1] & ~blink;
                led_o_nxt[cursor_p1] = base_o[cursor_p1] & ~blink;
            end
        end
    end

    // Stage 1: registered state and outputs
    always_ff @(posedge CLOCK_60Hz) begin
        if (reset) begin
            state_p1     <= IDLE;
            cursor_p1    <= 4'(CURSOR_RESET);
            home_p1      <= 4'(CURSOR_RESET);
            mask_p1      <= '0;
            step_p1      <= 3'd0;
            place_valid  <= 1'b0;
            place_reject <= 1'b0;
            place_cell   <= 4'd0;
            led_x        <= '0;
            led_o        <= '0;
        end else begin
            state_p1     <= state_nxt;
            cursor_p1    <= cursor_nxt;
            home_p1      <= home_nxt;
            mask_p1      <= mask_nxt;
            step_p1      <= step_nxt;
            place_valid  <= vld_nxt;
            place_reject <= rej_nxt;
            place_cell   <= vld_nxt ? cursor_p1 : 4'd0;
            led_x        <= led_x_nxt;
            led_o        <= led_o_nxt;
        end
    end

    assign cursor = cursor_p1;

endmodule

// File: tb/tb_ttt_cursor_display.sv
// Scoreboard bench for ttt_cursor_display: directed scenarios then random traffic,
// checked against a cell-walk reference model of cursor, placement and LEDs.
module tb_ttt_cursor_display;

    logic        CLOCK_60Hz = 1'b0;
    logic        reset = 1'b1;
    logic        blink = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_select = 1'b0;
    logic [17:0] board = '0;
    logic        player = 1'b0;
    logic        game_over = 1'b0;
    logic [3:0]  cursor;
    logic        place_valid, place_reject;
    logic [3:0]  place_cell;
    logic [8:0]  led_x, led_o;

    ttt_cursor_display dut (
        .CLOCK_60Hz   (CLOCK_60Hz),
        .reset        (reset),
        .blink        (blink),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_select   (btn_select),
        .board        (board),
        .player       (player),
        .game_over    (game_over),
        .cursor       (cursor),
        .place_valid  (place_valid),
        .place_reject (place_reject),
        .place_cell   (place_cell),
        .led_x        (led_x),
        .led_o        (led_o)
    );

    always #5 CLOCK_60Hz = ~CLOCK_60Hz;

    typedef struct packed {
        logic       after_reset;
        logic [3:0] cursor;
        logic       v;
        logic       r;
        logic [8:0] lx;
        logic [8:0] lo;
    } exp_t;

    exp_t       exq[$];
    logic [4:0] evq[$];      // {is_valid, cell}

    int         checks = 0;
    int         failures = 0;
    int         cyc_cnt = 0;

    int         m_cursor = 4;
    int         plan[$];
    logic [2:0] m_hist = 3'b111;

    function automatic bit occ_cell(input logic [17:0] b, input int i);
        logic [1:0] v;
        v = b[2*i +: 2];
        return (v == 2'b01) || (v == 2'b10);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; the model predicts what the DUT shows after the next edge.
    task automatic step(input logic rst_i, input logic [2:0] btn_i, input logic [17:0] brd_i,
                        input logic plr_i, input logic go_i, input logic blk_i);
        exp_t       e;
        logic [2:0] rise;
        logic [8:0] lx, lo, mask;
        int         c;
        @(negedge CLOCK_60Hz);
        reset      = rst_i;
        btn_left   = btn_i[0];
        btn_right  = btn_i[1];
        btn_select = btn_i[2];
        board      = brd_i;
        player     = plr_i;
        game_over  = go_i;
        blink      = blk_i;
        cyc_cnt++;
        e = '0;
        e.after_reset = rst_i;
        if (rst_i) begin
            m_cursor = 4;
            plan.delete();
            m_hist = 3'b111;
        end else begin
            c = m_cursor;
            for (int i = 0; i < 9; i++) begin
                lx[i] = (brd_i[2*i +: 2] == 2'b01);
                lo[i] = (brd_i[2*i +: 2] == 2'b10);
            end
            if (!go_i) begin
                if (!occ_cell(brd_i, c)) begin
                    if (plr_i) lo[c] = blk_i;
                    else       lx[c] = blk_i;
                end else begin
                    lx[c] = lx[c] & ~blk_i;
                    lo[c] = lo[c] & ~blk_i;
                end
            end
            e.lx = lx;
            e.lo = lo;
            rise   = btn_i & ~m_hist;
            m_hist = btn_i;
            if (plan.size() > 0) begin
                if (go_i) plan.delete();
                else      m_cursor = plan.pop_front();
            end else if (rise[2]) begin
                if (go_i || occ_cell(brd_i, c)) begin
                    e.r = 1'b1;
                    evq.push_back({1'b0, 4'(c)});
                end else begin
                    e.v = 1'b1;
                    evq.push_back({1'b1, 4'(c)});
                    for (int i = 0; i < 9; i++) mask[i] = occ_cell(brd_i, i);
                    mask[c] = 1'b1;
                    // Walk forward through the board; a full board lands back home.
                    for (int k = 1; k <= 8; k++) begin
                        int n;
                        n = (c + k) % 9;
                        if (!mask[n]) begin
                            plan.push_back(n);
                            break;
                        end
                        plan.push_back((k == 8) ? c : n);
                    end
                end
            end else if (!go_i && (rise[0] != rise[1])) begin
                m_cursor = rise[1] ? (c + 1) % 9 : (c + 8) % 9;
            end
        end
        e.cursor = 4'(m_cursor);
        exq.push_back(e);
    endtask

    function automatic logic bl();
        return cyc_cnt[1];
    endfunction

    task automatic press(input logic [2:0] btn_i, input logic [17:0] brd_i,
                         input logic plr_i, input logic go_i);
        step(1'b0, btn_i, brd_i, plr_i, go_i, bl());
        step(1'b0, 3'b000, brd_i, plr_i, go_i, bl());
    endtask

    task automatic idle(input int n, input logic [17:0] brd_i, input logic plr_i, input logic go_i);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, brd_i, plr_i, go_i, bl());
    endtask

    function automatic logic [17:0] rand_board();
        logic [17:0] b;
        int          r;
        for (int i = 0; i < 9; i++) begin
            r = $urandom_range(0, 7);
            b[2*i +: 2] = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
        end
        if ($urandom_range(0, 5) == 0) begin
            for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'b01;
            b[2*$urandom_range(0, 8) +: 2] = 2'b00;
        end
        return b;
    endfunction

    // Monitor: compares every presented cycle and every placement pulse.
    initial begin
        exp_t       e;
        logic [4:0] ev;
        forever begin
            @(posedge CLOCK_60Hz);
            #1;
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("cursor", 32'(cursor), 32'(e.cursor));
                chk("led_x", 32'(led_x), 32'(e.lx));
                chk("led_o", 32'(led_o), 32'(e.lo));
                chk("place_valid", 32'(place_valid), 32'(e.v));
                chk("place_reject", 32'(place_reject), 32'(e.r));
                if (e.after_reset) chk("place_cell_reset", 32'(place_cell), 32'd0);
            end
            if (place_valid === 1'b1 || place_reject === 1'b1) begin
                if (evq.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, place_valid, place_reject}, 32'd0);
                end else begin
                    ev = evq.pop_front();
                    chk("pulse_kind", {30'd0, place_valid, place_reject},
                        ev[4] ? 32'd2 : 32'd1);
                    if (ev[4]) chk("place_cell", 32'(place_cell), 32'(ev[3:0]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] full_x, one_o, brd;
        logic [2:0]  btn;
        logic        go, plr;

        full_x = '0;
        for (int i = 0; i < 9; i++) full_x[2*i +: 2] = (i == 4) ? 2'b00 : 2'b01;
        one_o = '0;
        one_o[9:8] = 2'b10;

        // Right held through reset, then released and pressed once.
        for (int i = 0; i < 3; i++) step(1'b1, 3'b010, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0);
        press(3'b010, '0, 1'b0, 1'b0);

        // Wrap at both ends and simultaneous left+right.
        for (int i = 0; i < 3; i++) press(3'b010, '0, 1'b0, 1'b0);
        press(3'b010, '0, 1'b0, 1'b0);
        press(3'b001, '0, 1'b0, 1'b0);
        press(3'b011, '0, 1'b0, 1'b0);

        // Empty board placement, then blink on the new cursor cell.
        step(1'b1, 3'b000, '0, 1'b0, 1'b0, 1'b0);
        press(3'b100, '0, 1'b0, 1'b0);
        idle(8, '0, 1'b0, 1'b0);

        // Only the centre free: full search returns to the placed cell.
        step(1'b1, 3'b000, full_x, 1'b0, 1'b0, 1'b0);
        press(3'b100, full_x, 1'b0, 1'b0);
        idle(10, full_x, 1'b0, 1'b0);

        // Select on an O cell is rejected; occupied cursor cell blinks off.
        step(1'b1, 3'b000, one_o, 1'b1, 1'b0, 1'b0);
        idle(4, one_o, 1'b1, 1'b0);
        press(3'b100, one_o, 1'b1, 1'b0);
        idle(4, one_o, 1'b1, 1'b0);

        // game_over: reject, frozen cursor, base LEDs only.
        step(1'b1, 3'b000, one_o, 1'b0, 1'b1, 1'b0);
        press(3'b100, one_o, 1'b0, 1'b1);
        press(3'b010, one_o, 1'b0, 1'b1);
        press(3'b001, one_o, 1'b0, 1'b1);
        idle(4, one_o, 1'b0, 1'b1);

        // Randomized traffic including resets and aborts mid-search.
        brd = rand_board();
        btn = 3'b000;
        go  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) brd = rand_board();
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 2) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 19) == 0) go = ~go;
            plr = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 79) == 0), btn, brd, plr, go, 1'($urandom_range(0, 1)));
        end

        @(posedge CLOCK_60Hz);
        @(posedge CLOCK_60Hz);
        #2;
        chk("scoreboard_drained", 32'(exq.size()), 32'd0);
        chk("events_drained", 32'(evq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
